// File: rtl/debug_unit_pkg.sv
// Shared constants, state encoding and helpers for the UART debug controller.
package debug_unit_pkg;

  localparam int LEN        = 32;
  localparam int IMEM_AW    = 8;
  localparam int N_REGS     = 32;
  localparam int DUMP_WORDS = N_REGS + 2;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_CNT,
    LOAD_BYTE,
    LOAD_WRITE,
    LOAD_DONE,
    ACK_WAIT,
    RUN,
    STEP,
    DUMP_LOAD,
    DUMP_SEND,
    DUMP_WAIT
  } state_t;

  // True for the index of the final word of the dump stream (last register).
  function automatic logic isLastWord(input logic [5:0] idx);
    return idx == 6'(DUMP_WORDS - 1);
  endfunction

endpackage

// File: rtl/debug_unit_if.sv
// Bundle of the UART, instruction-memory, pipeline-control and register-debug
// signals seen by the debug controller. master = controller side.
interface debug_unit_if;
  import debug_unit_pkg::*;

  logic [7:0]         rx_data;
  logic               rx_done;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_done;
  logic               imem_wr_en;
  logic [IMEM_AW-1:0] imem_addr;
  logic [LEN-1:0]     imem_data;
  logic               cpu_enable;
  logic               cpu_clear;
  logic               halt;
  logic [LEN-1:0]     pc_value;
  logic [4:0]         reg_addr;
  logic [LEN-1:0]     reg_data;
  logic               busy;

  modport master (
    input  rx_data, rx_done, tx_done, halt, pc_value, reg_data,
    output tx_data, tx_start, imem_wr_en, imem_addr, imem_data,
           cpu_enable, cpu_clear, reg_addr, busy
  );

  modport slave (
    output rx_data, rx_done, tx_done, halt, pc_value, reg_data,
    input  tx_data, tx_start, imem_wr_en, imem_addr, imem_data,
           cpu_enable, cpu_clear, reg_addr, busy
  );

endinterface

// File: rtl/debug_unit_shifter.sv
// 4-byte MSB-first word register with a byte index. Bytes shifted in assemble
// a word (program load); a loaded word is read back one byte at a time (dump).
module byte_word_shifter
  import debug_unit_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_clear,
  input  logic           i_load,
  input  logic [LEN-1:0] i_word,
  input  logic           i_shift,
  input  logic [7:0]     i_byte,
  input  logic           i_advance,
  output logic [LEN-1:0] o_word,
  output logic [7:0]     o_byte,
  output logic           o_last
);

  logic [LEN-1:0] r_word;
  logic [1:0]     r_idx;

  // Word register and byte index; clear beats load beats shift beats advance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[LEN-9:0], i_byte};
      r_idx  <= r_idx + 2'd1;
    end else if (i_advance) begin
      r_idx  <= r_idx + 2'd1;
    end
  end

  // Byte selected by the index, most significant byte first.
  always_comb begin
    o_byte = r_word[31:24];
    case (r_idx)
      2'd0: o_byte = r_word[31:24];
      2'd1: o_byte = r_word[23:16];
      2'd2: o_byte = r_word[15:8];
      2'd3: o_byte = r_word[7:0];
      default: o_byte = r_word[31:24];
    endcase
  end

  assign o_word = r_word;
  assign o_last = (r_idx == 2'd3);

endmodule

// File: rtl/debug_unit.sv
// UART-side debug controller for the MIPS pipeline: loads programs into
// instruction memory, runs or single-steps the core and streams a state dump.
module debug_unit
  import debug_unit_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  debug_unit_if.master bus
);

  state_t             r_state, w_nextState;
  logic               r_cpuEn, w_cpuEnNext;
  logic [7:0]         r_wordCnt;
  logic [IMEM_AW-1:0] r_imemAddr;
  logic [5:0]         r_wordIdx;
  logic [LEN-1:0]     r_cycleCnt;
  logic [LEN-1:0]     r_cntCap;

  logic           w_shClear, w_shLoad, w_shShift, w_shAdvance, w_shLast;
  logic [LEN-1:0] w_shWordIn, w_shWordOut;
  logic [7:0]     w_shByte;

  logic w_setCount, w_wordWritten, w_clrCycles;
  logic w_dumpStart, w_dumpEnd, w_nextWord, w_capture;
  logic w_imemWrEn, w_cpuClear, w_txStart;
  logic [7:0] w_txData;

  byte_word_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_shClear),
    .i_load    (w_shLoad),
    .i_word    (w_shWordIn),
    .i_shift   (w_shShift),
    .i_byte    (bus.rx_data),
    .i_advance (w_shAdvance),
    .o_word    (w_shWordOut),
    .o_byte    (w_shByte),
    .o_last    (w_shLast)
  );

  // State register and the registered pipeline enable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cpuEn <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cpuEn <= w_cpuEnNext;
    end
  end

  // Next-state, strobes and combinational outputs for every controller state.
  always_comb begin
    w_nextState   = r_state;
    w_cpuEnNext   = 1'b0;
    w_shClear     = 1'b0;
    w_shLoad      = 1'b0;
    w_shShift     = 1'b0;
    w_shAdvance   = 1'b0;
    w_shWordIn    = bus.reg_data;
    w_setCount    = 1'b0;
    w_wordWritten = 1'b0;
    w_clrCycles   = 1'b0;
    w_dumpStart   = 1'b0;
    w_dumpEnd     = 1'b0;
    w_nextWord    = 1'b0;
    w_capture     = 1'b0;
    w_imemWrEn    = 1'b0;
    w_cpuClear    = 1'b0;
    w_txStart     = 1'b0;
    w_txData      = 8'h00;
    case (r_state)
      IDLE: begin
        if (bus.rx_done) begin
          case (bus.rx_data)
            CMD_LOAD: w_nextState = LOAD_CNT;
            CMD_RUN:  w_nextState = RUN;
            CMD_STEP: w_nextState = STEP;
            default:  w_nextState = IDLE;
          endcase
        end
      end
      LOAD_CNT: begin
        if (bus.rx_done) begin
          w_setCount  = 1'b1;
          w_shClear   = 1'b1;
          w_nextState = (bus.rx_data == 8'd0) ? LOAD_DONE : LOAD_BYTE;
        end
      end
      LOAD_BYTE: begin
        if (bus.rx_done) begin
          w_shShift = 1'b1;
          if (w_shLast) w_nextState = LOAD_WRITE;
        end
      end
      LOAD_WRITE: begin
        w_imemWrEn    = 1'b1;
        w_wordWritten = 1'b1;
        w_nextState   = (r_wordCnt == 8'd1) ? LOAD_DONE : LOAD_BYTE;
      end
      LOAD_DONE: begin
        w_cpuClear  = 1'b1;
        w_clrCycles = 1'b1;
        w_txStart   = 1'b1;
        w_txData    = ACK_BYTE;
        w_nextState = ACK_WAIT;
      end
      ACK_WAIT: begin
        w_txData = ACK_BYTE;
        if (bus.tx_done) w_nextState = IDLE;
      end
      RUN: begin
        if (bus.halt) begin
          w_dumpStart = 1'b1;
          w_nextState = DUMP_LOAD;
        end else begin
          w_cpuEnNext = 1'b1;
        end
      end
      STEP: begin
        if (bus.halt || r_cpuEn) begin
          w_dumpStart = 1'b1;
          w_nextState = DUMP_LOAD;
        end else begin
          w_cpuEnNext = 1'b1;
        end
      end
      DUMP_LOAD: begin
        w_shLoad = 1'b1;
        if (r_wordIdx == 6'd0) begin
          w_shWordIn = bus.pc_value;
          w_capture  = 1'b1;
        end else if (r_wordIdx == 6'd1) begin
          w_shWordIn = r_cntCap;
        end
        w_nextState = DUMP_SEND;
      end
      DUMP_SEND: begin
        w_txStart   = 1'b1;
        w_txData    = w_shByte;
        w_nextState = DUMP_WAIT;
      end
      DUMP_WAIT: begin
        w_txData = w_shByte;
        if (bus.tx_done) begin
          w_shAdvance = 1'b1;
          if (!w_shLast) begin
            w_nextState = DUMP_SEND;
          end else if (isLastWord(r_wordIdx)) begin
            w_dumpEnd   = 1'b1;
            w_nextState = IDLE;
          end else begin
            w_nextWord  = 1'b1;
            w_nextState = DUMP_LOAD;
          end
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Load word count, imem address, dump word index and cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wordCnt  <= '0;
      r_imemAddr <= '0;
      r_wordIdx  <= '0;
      r_cycleCnt <= '0;
      r_cntCap   <= '0;
    end else begin
      if (w_setCount) begin
        r_wordCnt  <= bus.rx_data;
        r_imemAddr <= '0;
      end else if (w_wordWritten) begin
        r_wordCnt  <= r_wordCnt - 8'd1;
        r_imemAddr <= r_imemAddr + IMEM_AW'(1);
      end
      if (w_dumpStart || w_dumpEnd) begin
        r_wordIdx <= '0;
      end else if (w_nextWord) begin
        r_wordIdx <= r_wordIdx + 6'd1;
      end
      if (w_capture) r_cntCap <= r_cycleCnt;
      if (w_clrCycles) begin
        r_cycleCnt <= '0;
      end else if (r_cpuEn) begin
        r_cycleCnt <= r_cycleCnt + 32'd1;
      end
    end
  end

  assign bus.tx_data    = w_txData;
  assign bus.tx_start   = w_txStart;
  assign bus.imem_wr_en = w_imemWrEn;
  assign bus.imem_addr  = r_imemAddr;
  assign bus.imem_data  = w_shWordOut;
  assign bus.cpu_enable = r_cpuEn;
  assign bus.cpu_clear  = w_cpuClear;
  assign bus.reg_addr   = (r_wordIdx >= 6'd2) ? 5'(r_wordIdx - 6'd2) : 5'd0;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Directed testbench for debug_unit: load, step, run, ignored input and reset.
module tb_debug_unit;

  logic clk = 1'b0;
  logic reset;

  debug_unit_if bus ();

  debug_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0]  txq [$];
  logic [7:0]  wrAddr [$];
  logic [31:0] wrData [$];
  int enCount  = 0;
  int clrCount = 0;

  logic [7:0] loadSeq [10] = '{8'h4C, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                               8'hDE, 8'hAD, 8'hBE, 8'hEF};

  int txBase, wrBase, clrBase, enBase;

  always #5 clk = ~clk;

  // Register file model: every register reads as C0DE00xx with xx its index.
  assign bus.reg_data = 32'hC0DE0000 | {27'd0, bus.reg_addr};

  // Observe imem writes, enable cycles and clear pulses away from the clock edge.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.imem_wr_en) begin
        wrAddr.push_back(bus.imem_addr);
        wrData.push_back(bus.imem_data);
      end
      if (bus.cpu_enable) enCount++;
      if (bus.cpu_clear) clrCount++;
    end
  end

  // UART transmitter model: capture each launched byte, answer with tx_done.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.tx_done = 1'b0;
      if (bus.tx_start) begin
        txq.push_back(bus.tx_data);
        repeat (2) @(negedge clk);
        bus.tx_done = 1'b1;
      end
    end
  end

  // Global time limit so the bench always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] getWord(input int pos);
    if (pos < 0 || txq.size() < pos + 4) return 'x;
    return {txq[pos], txq[pos+1], txq[pos+2], txq[pos+3]};
  endfunction

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    @(negedge clk);
    bus.rx_done = 1'b0;
  endtask

  task automatic waitIdle(input int budget, input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < budget);
    checkOutput(tag, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic checkDump(input string tag, input int base, input logic [31:0] pc,
                           input logic [31:0] cnt);
    int bad = 0;
    checkOutput({tag, "_len"}, 32'(txq.size() - base), 32'd136);
    checkOutput({tag, "_pc"}, getWord(base), pc);
    checkOutput({tag, "_cnt"}, getWord(base + 4), cnt);
    for (int k = 0; k < 32; k++) begin
      if (getWord(base + 8 + 4 * k) !== (32'hC0DE0000 | 32'(k))) bad++;
    end
    checkOutput({tag, "_regs_bad"}, 32'(bad), 32'd0);
    checkOutput({tag, "_r31"}, getWord(base + 132), 32'hC0DE001F);
  endtask

  initial begin
    reset        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_done  = 1'b0;
    bus.halt     = 1'b0;
    bus.pc_value = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", {27'd0, bus.busy, bus.tx_start, bus.cpu_enable,
                             bus.imem_wr_en, bus.cpu_clear}, 32'd0);
    checkOutput("rst_txdata", {24'd0, bus.tx_data}, 32'd0);
    checkOutput("rst_imem", bus.imem_data, 32'd0);
    checkOutput("rst_regaddr", {27'd0, bus.reg_addr}, 32'd0);
    reset = 1'b1;

    // Unknown byte in IDLE is ignored
    applyStimulus(8'h7A);
    @(negedge clk);
    checkOutput("ignore_7A_busy", {31'd0, bus.busy}, 32'd0);

    // Two-word program load
    txBase = txq.size(); wrBase = wrAddr.size(); clrBase = clrCount;
    for (int i = 0; i < 10; i++) applyStimulus(loadSeq[i]);
    checkOutput("load_busy", {31'd0, bus.busy}, 32'd1);
    waitIdle(200, "load_idle");
    checkOutput("load_nwr", 32'(wrAddr.size() - wrBase), 32'd2);
    if (wrAddr.size() >= wrBase + 2) begin
      checkOutput("load_a0", {24'd0, wrAddr[wrBase]}, 32'd0);
      checkOutput("load_d0", wrData[wrBase], 32'h00000001);
      checkOutput("load_a1", {24'd0, wrAddr[wrBase+1]}, 32'd1);
      checkOutput("load_d1", wrData[wrBase+1], 32'hDEADBEEF);
    end
    checkOutput("load_clr", 32'(clrCount - clrBase), 32'd1);
    checkOutput("load_ntx", 32'(txq.size() - txBase), 32'd1);
    if (txq.size() > txBase) checkOutput("load_ack", {24'd0, txq[txBase]}, 32'h4B);

    // Load with zero words
    txBase = txq.size(); wrBase = wrAddr.size(); clrBase = clrCount;
    applyStimulus(8'h4C);
    applyStimulus(8'h00);
    waitIdle(200, "load0_idle");
    checkOutput("load0_nwr", 32'(wrAddr.size() - wrBase), 32'd0);
    checkOutput("load0_clr", 32'(clrCount - clrBase), 32'd1);
    checkOutput("load0_ntx", 32'(txq.size() - txBase), 32'd1);
    if (txq.size() > txBase) checkOutput("load0_ack", {24'd0, txq[txBase]}, 32'h4B);

    // Single step
    bus.pc_value = 32'h4;
    txBase = txq.size(); enBase = enCount;
    applyStimulus(8'h53);
    waitIdle(3000, "step_idle");
    checkOutput("step_en", 32'(enCount - enBase), 32'd1);
    checkDump("step", txBase, 32'h4, 32'd1);

    // Continuous run after clearing the cycle counter
    applyStimulus(8'h4C);
    applyStimulus(8'h00);
    waitIdle(200, "clr_idle");
    bus.pc_value = 32'h40;
    txBase = txq.size(); enBase = enCount;
    applyStimulus(8'h43);
    begin
      int n = 0, t = 0;
      while (n < 10 && t < 200) begin
        @(negedge clk);
        t++;
        if (bus.cpu_enable) n++;
      end
      checkOutput("run_10en", 32'(n), 32'd10);
    end
    @(posedge clk);
    #1 bus.halt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("run_en_drop", {31'd0, bus.cpu_enable}, 32'd0);
    waitIdle(3000, "run_idle");
    checkOutput("run_en", 32'(enCount - enBase), 32'd11);
    checkDump("run", txBase, 32'h40, 32'h0000000B);
    bus.halt = 1'b0;

    // rx_done during a dump is neither acted on nor queued
    bus.pc_value = 32'h8;
    txBase = txq.size();
    applyStimulus(8'h53);
    begin
      int t = 0;
      while (txq.size() < txBase + 20 && t < 2000) begin
        @(negedge clk);
        t++;
      end
    end
    applyStimulus(8'h4C);
    waitIdle(3000, "rxdump_idle");
    checkDump("rxdump", txBase, 32'h8, 32'd12);
    repeat (5) @(negedge clk);
    checkOutput("rxdump_stay_idle", {31'd0, bus.busy}, 32'd0);

    // Step while halted: dump only
    bus.halt = 1'b1;
    bus.pc_value = 32'h10;
    txBase = txq.size(); enBase = enCount;
    applyStimulus(8'h53);
    waitIdle(3000, "hstep_idle");
    checkOutput("hstep_en", 32'(enCount - enBase), 32'd0);
    checkDump("hstep", txBase, 32'h10, 32'd12);
    bus.halt = 1'b0;

    // Reset in the middle of a load
    wrBase = wrAddr.size();
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    applyStimulus(8'hAA);
    applyStimulus(8'hBB);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("mid_rst_ctrl", {27'd0, bus.busy, bus.tx_start, bus.cpu_enable,
                                 bus.imem_wr_en, bus.cpu_clear}, 32'd0);
    checkOutput("mid_rst_imem", bus.imem_data, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    checkOutput("mid_rst_nwr", 32'(wrAddr.size() - wrBase), 32'd0);

    // Load accepted normally after the abort
    txBase = txq.size(); wrBase = wrAddr.size();
    applyStimulus(8'h4C);
    applyStimulus(8'h01);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    applyStimulus(8'h44);
    waitIdle(200, "reload_idle");
    checkOutput("reload_nwr", 32'(wrAddr.size() - wrBase), 32'd1);
    if (wrAddr.size() > wrBase) begin
      checkOutput("reload_a0", {24'd0, wrAddr[wrBase]}, 32'd0);
      checkOutput("reload_d0", wrData[wrBase], 32'h11223344);
    end
    if (txq.size() > txBase) checkOutput("reload_ack", {24'd0, txq[txBase]}, 32'h4B);
    else checkOutput("reload_ntx", 32'(txq.size() - txBase), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
